// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port, with a per-register busy
// scoreboard that decode uses for RAW stalls and WAW detection.
module regfile_wb_arbiter #(
  parameter int ADDR_SIZE = 5,
  parameter int XLEN      = 64,
  parameter int NUM_REQ   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]      req_data,
  output logic                         rf_write_enable,
  output logic [ADDR_SIZE-1:0]         rf_write_addr,
  output logic [XLEN-1:0]              rf_write_data,
  input  logic                         rsv_valid,
  input  logic [ADDR_SIZE-1:0]         rsv_addr,
  input  logic [ADDR_SIZE-1:0]         chk_addr1,
  input  logic [ADDR_SIZE-1:0]         chk_addr2,
  output logic                         chk_busy1,
  output logic                         chk_busy2,
  output logic                         rsv_conflict
);

  localparam int NUM_REGS = 1 << ADDR_SIZE;
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_SIZE-1:0] addr_arr [NUM_REQ];
  logic [XLEN-1:0]      data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_SIZE +: ADDR_SIZE];
      assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
    end
  endgenerate

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     win_idx;
  logic                 grant;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic                 conflict_q, conflict_d;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [XLEN-1:0]      win_data;

  // Round-robin search from the pointer; ready is a function of valid, pointer and rst only.
  always_comb begin
    int idx;
    req_ready = '0;
    grant     = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rst && !grant && req_valid[idx]) begin
        grant          = 1'b1;
        win_idx        = PTR_W'(idx);
        req_ready[idx] = 1'b1;
      end
    end
  end

  assign win_addr = addr_arr[win_idx];
  assign win_data = data_arr[win_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant) begin
      we_d    = (win_addr != '0);
      waddr_d = win_addr;
      wdata_d = win_data;
    end
  end

  // Commit clears first so that a same-cycle reservation of that register wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
    busy_d[0]  = 1'b0;
    conflict_d = rsv_valid && (rsv_addr != '0) && busy_q[rsv_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;
  assign rsv_conflict    = conflict_q;
  assign chk_busy1       = busy_q[chk_addr1];
  assign chk_busy2       = busy_q[chk_addr2];

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback producers: integer ALU, load unit and mul/div unit.
- Uses round-robin arbitration with valid/ready handshakes and a one-cycle registered output stage that drives the register file's write_enable, write_addr and write_data.
- Holds a per-register busy scoreboard: decode reserves a destination at issue, and the matching writeback commit clears it. Decode uses the busy outputs to stall on RAW hazards.

Parameters:
- ADDR_SIZE, 5, register address width.
- XLEN, 64, data width.
- NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = load, 2 = mul/div).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  per-requester writeback valid
- req_ready  output  NUM_REQ  per-requester grant; transfer when valid&ready
- req_addr  input  NUM_REQ*ADDR_SIZE  destination register; requester i occupies slice [i*ADDR_SIZE +: ADDR_SIZE]
- req_data  input  NUM_REQ*XLEN  writeback data; requester i occupies slice [i*XLEN +: XLEN]
- rf_write_enable  output  1  register file write enable (registered)
- rf_write_addr  output  ADDR_SIZE  register file write address (registered)
- rf_write_data  output  XLEN  register file write data (registered)
- rsv_valid  input  1  decode reserves a destination this cycle
- rsv_addr  input  ADDR_SIZE  register being reserved
- chk_addr1  input  ADDR_SIZE  decode source operand 1
- chk_addr2  input  ADDR_SIZE  decode source operand 2
- chk_busy1  output  1  source 1 has a pending write
- chk_busy2  output  1  source 2 has a pending write
- rsv_conflict  output  1  registered flag: reservation hit an already-busy register (WAW)

Behaviour:

Reset:
- rf_write_enable = 0, rf_write_addr = 0, rf_write_data = 0.
- All busy bits = 0, rsv_conflict = 0, round-robin pointer = 0.
- req_ready = all 0 while rst is high, including when reset is asserted mid-operation. In-flight requests are dropped, and requesters must re-present after reset.

Arbitration (combinational, cycle N):
- Search req_valid starting at the pointer index, wrapping modulo NUM_REQ. The first valid index wins.
- Only the winner's req_ready = 1. With no valid requests, all req_ready = 0.
- req_ready never depends on anything except req_valid, the pointer and rst.
- A non-granted requester keeps valid, addr and data stable until granted. No request is starved: worst-case wait is NUM_REQ-1 grants.

Pointer update:
- On a grant to i, the pointer becomes (i+1) mod NUM_REQ at the next edge.
- With no grant, the pointer holds.

Output stage (cycle N+1):
- On a grant, at the edge: rf_write_enable <= (winner addr != 0), rf_write_addr <= winner addr, rf_write_data <= winner data.
- With no grant: rf_write_enable <= 0. Addr and data hold their previous values.
- Latency from handshake to write port: exactly 1 cycle. Throughput: 1 write per cycle.
- A write to x0 is accepted (ready asserted, pointer advances) but never produces a write enable and never touches the scoreboard.

Scoreboard (busy[31:0], busy[0] always 0):
- Commit: when rf_write_enable = 1 (cycle N+1), clear busy[rf_write_addr] at the following edge.
- Reserve: when rsv_valid and rsv_addr != 0, set busy[rsv_addr] at the edge.
- Reserve and commit to the same register in the same cycle: set wins, so the register stays busy for the new producer.
- rsv_conflict <= rsv_valid & (rsv_addr != 0) & busy[rsv_addr], registered and valid for one cycle. The register stays busy.
- chk_busyN = busy[chk_addrN], combinational from state. There is no bypass of a same-cycle commit, so the result is conservative: decode stalls until the cycle after the commit. chk_addr = 0 always reports 0.

Test Plan:
1. Reset: hold rst 2 cycles with all req_valid = 1 -> req_ready = 000, rf_write_enable = 0, chk_busy1/2 = 0; after release the first grant goes to requester 0.
2. Round-robin: all three valid continuously with addrs 5/6/7 and data 0xA/0xB/0xC -> grants 0,1,2,0 on consecutive cycles; rf_write_addr sequence 5,6,7,5, each one cycle after its grant, with write enable high every cycle.
3. Scoreboard lifecycle: reserve x9, then chk_addr1 = 9 -> chk_busy1 = 1; ALU writes x9 = 0x1234 -> rf_write_enable the next cycle; chk_busy1 = 0 one cycle after that.
4. x0 write: requester 1 valid with addr 0 and data 0xFFFF -> req_ready[1] = 1, rf_write_enable stays 0, pointer advances to 2.
5. Same-cycle reserve and commit to x12 -> busy[12] remains 1 and chk_busy2 (addr 12) = 1; reserve x12 again while busy -> rsv_conflict = 1 for one cycle.
6. Mid-operation reset: assert rst the cycle after a grant -> rf_write_enable = 0 the next cycle, all busy bits cleared, pointer = 0.
